// File: rtl/pyc_sync_mem_reader_pkg.sv
// Shared definitions for the synchronous memory read initiator: read latency,
// credit-counter sizing and response-entry field layout.
package pyc_sync_mem_reader_pkg;

    // Cycles from mem_ren to valid mem_rdata.
    localparam int unsigned RdLatency = 1;

    // Response entry layout: data in the low bits, error flag just above it.
    localparam int unsigned RspDataOff = 0;

    function automatic int unsigned rsp_err_off(int unsigned data_width);
        return data_width;
    endfunction

    // Width able to hold 0..depth inclusive.
    function automatic int unsigned cred_width(int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/pyc_sync_mem_reader_if.sv
// Request, response and memory-port signals of the read initiator.
interface pyc_sync_mem_reader_if #(
    parameter int unsigned ADDR_WIDTH = 64,
    parameter int unsigned DATA_WIDTH = 64
);
    logic                  req_valid;
    logic                  req_ready;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_data;
    logic                  rsp_err;
    logic                  mem_ren;
    logic [ADDR_WIDTH-1:0] mem_raddr;
    logic [DATA_WIDTH-1:0] mem_rdata;

    // Requester plus memory side.
    modport master (
        output req_valid, req_addr, rsp_ready, mem_rdata,
        input  req_ready, rsp_valid, rsp_data, rsp_err, mem_ren, mem_raddr
    );

    // The reader itself.
    modport slave (
        input  req_valid, req_addr, rsp_ready, mem_rdata,
        output req_ready, rsp_valid, rsp_data, rsp_err, mem_ren, mem_raddr
    );
endinterface

// File: rtl/pyc_rsp_fifo.sv
// Response FIFO with registered head outputs and occupancy; pointers wrap at DEPTH,
// so non-power-of-two depths work. Storage is not reset.
module pyc_rsp_fifo
    import pyc_sync_mem_reader_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 65
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          push,
    input  logic [WIDTH-1:0]              push_data,
    input  logic                          pop,
    output logic                          out_valid,
    output logic [WIDTH-1:0]              out_data,
    output logic [cred_width(DEPTH)-1:0]  occ
);
    localparam int unsigned CW = cred_width(DEPTH);
    localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef logic [CW-1:0] ptr_t;

    logic [WIDTH-1:0] store_q [2**IW];
    ptr_t             wr_ptr_q, wr_ptr_d;
    ptr_t             rd_ptr_q, rd_ptr_d;
    ptr_t             occ_q, occ_d;
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;

    function automatic ptr_t ptr_inc(ptr_t p);
        return (p == ptr_t'(DEPTH - 1)) ? '0 : p + ptr_t'(1);
    endfunction

    always_comb begin
        wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        occ_d    = occ_q + ptr_t'(push) - ptr_t'(pop);
        valid_d  = (occ_d != '0);
        data_d   = data_q;
        // The new head is the incoming word when it lands on the read slot this edge.
        if (occ_d != '0) begin
            if (push && (wr_ptr_q == rd_ptr_d)) begin
                data_d = push_data;
            end else begin
                data_d = store_q[rd_ptr_d[IW-1:0]];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            store_q[wr_ptr_q[IW-1:0]] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            valid_q  <= 1'b0;
            data_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            valid_q  <= valid_d;
            data_q   <= data_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign occ       = occ_q;

endmodule

// File: rtl/pyc_sync_mem_reader.sv
// Read initiator for a 1-cycle registered-read memory with credit-protected response FIFO.
// Optional range check enabled by defining PYC_MEM_RD_RANGE_CHECK_EN.
module pyc_sync_mem_reader
    import pyc_sync_mem_reader_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 64,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned DEPTH      = 1024,
    parameter int unsigned RSP_DEPTH  = 2
) (
    input logic                   clk,
    input logic                   rst,
    pyc_sync_mem_reader_if.slave  bus
);
    localparam int unsigned CW     = cred_width(RSP_DEPTH);
    localparam int unsigned CW1    = CW + 1;
    localparam int unsigned EW     = DATA_WIDTH + 1;
    localparam int unsigned ErrOff = rsp_err_off(DATA_WIDTH);

`ifdef PYC_MEM_RD_RANGE_CHECK_EN
    localparam bit RangeChk = 1'b1;
`else
    localparam bit RangeChk = 1'b0;
`endif

    logic          inflight_q;
    logic          inflight_err_q;
    logic [CW-1:0] occ;
    logic [CW1-1:0] used;
    logic          req_ready;
    logic          fire;
    logic          pop;
    logic          addr_err;
    logic          head_valid;
    logic [EW-1:0] head;
    logic [EW-1:0] push_entry;

    assign pop = head_valid && bus.rsp_ready;

    // Credits already spoken for, crediting back an entry leaving this cycle.
    assign used      = {1'b0, occ} + CW1'(inflight_q) - CW1'(pop);
    assign req_ready = !rst && (used < CW1'(RSP_DEPTH));
    assign fire      = bus.req_valid && req_ready;

    assign addr_err = RangeChk && (bus.req_addr >= ADDR_WIDTH'(DEPTH));

    assign bus.req_ready = req_ready;
    assign bus.mem_ren   = fire && !addr_err;
    assign bus.mem_raddr = bus.req_addr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight_q     <= 1'b0;
            inflight_err_q <= 1'b0;
        end else begin
            inflight_q     <= fire;
            inflight_err_q <= fire && addr_err;
        end
    end

    always_comb begin
        push_entry = '0;
        push_entry[RspDataOff +: DATA_WIDTH] = inflight_err_q ? '0 : bus.mem_rdata;
        push_entry[ErrOff] = inflight_err_q;
    end

    pyc_rsp_fifo #(
        .DEPTH (RSP_DEPTH),
        .WIDTH (EW)
    ) u_rsp_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (inflight_q),
        .push_data (push_entry),
        .pop       (pop),
        .out_valid (head_valid),
        .out_data  (head),
        .occ       (occ)
    );

    assign bus.rsp_valid = head_valid;
    assign bus.rsp_data  = head[RspDataOff +: DATA_WIDTH];
    assign bus.rsp_err   = head[ErrOff];

endmodule
